// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - state, opcode/funct and control encodings for the multicycle MIPS controller
// Optional encodings guarded by MIPS_CTRL_BNE_ORI_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_ORIEX   = 4'd13,
    S_ORIWB   = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MIPS_CTRL_BNE_ORI_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - maps {alu_op, funct} to alu_control and flags supported R-type functs
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  logic [2:0] funct_ctl;

  always_comb begin
    funct_valid = 1'b1;
    funct_ctl   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_ctl = ALU_ADD;
      FN_SUB:  funct_ctl = ALU_SUB;
      FN_AND:  funct_ctl = ALU_AND;
      FN_OR:   funct_ctl = ALU_OR;
      FN_SLT:  funct_ctl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase

    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctl;
      default:     alu_control = ALU_OR;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - control FSM sequencing the shared multicycle MIPS datapath
// Optional bne/ori support is enabled by defining MIPS_CTRL_BNE_ORI_EN.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [2:0] alu_control,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic [2:0] alu_ctl_raw;
  logic       funct_valid;
  logic       pc_write, branch_eq, branch_ne;

  mips_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_ctl_raw),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_src     = PC_ALU;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    imm_zext   = 1'b0;
    alu_op     = ALUOP_ADD;
    illegal    = 1'b0;
    pc_write   = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_4;
        // IR load and PC+4 fire only on the completing cycle, so stalls never double-increment
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM4;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_valid) state_d = S_RTYPEEX;
            else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BEQEX;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JEX;
`ifdef MIPS_CTRL_BNE_ORI_EN
          OP_BNE:  state_d = S_BNEEX;
          OP_ORI:  state_d = S_ORIEX;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_ALUOUT;
        branch_eq = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JEX: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MIPS_CTRL_BNE_ORI_EN
      S_BNEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_ALUOUT;
        branch_ne = 1'b1;
        state_d   = S_FETCH;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        imm_zext  = 1'b1;
        alu_op    = ALUOP_OR;
        state_d   = S_ORIWB;
      end
      S_ORIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    pc_en       = pc_write | (branch_eq & zero) | (branch_ne & ~zero);
    alu_control = alu_ctl_raw;

    // Reset is async, so quiesce every output combinationally rather than waiting for an edge
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      imm_zext    = 1'b0;
      alu_control = 3'b000;
      illegal     = 1'b0;
    end
  end

endmodule
